// File: rtl/pixel_readout_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_readout_scheduler
//  Purpose  : Per-column readout sequencer. It queues L1As and, for each one,
//             loads the switch-cell chain, drains it and frames the event.
//  Options  : STATUS_COUNTERS_EN adds free-running status counters.
//  Revision : 1.0  initial release
// ============================================================================
module pixel_readout_scheduler #(
   parameter int L1ADDRWIDTH   = 7,
   parameter int DATAWIDTH     = 46,
   parameter int FIFO_AW       = 2,
   parameter int SETTLE_CYCLES = 2,
   parameter int MAX_HITS      = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   inL1A,
   input  logic [L1ADDRWIDTH-1:0] inL1Addr,
   input  logic [11:0]            inBCID,
   input  logic                   dnUnreadHit,
   input  logic [DATAWIDTH-1:0]   dnData,
   input  logic                   streamBufAlmostFull,
   output logic                   dnLoad,
   output logic [L1ADDRWIDTH-1:0] dnL1Addr,
   output logic                   dnRead,
   output logic [DATAWIDTH-1:0]   dout,
   output logic [1:0]             doutType,
   output logic                   busy,
   output logic                   l1aOverflow
`ifdef STATUS_COUNTERS_EN
   ,
   output logic [31:0]            l1aCount,
   output logic [31:0]            hitCount,
   output logic [31:0]            readCount,
   output logic [31:0]            eventCount
`endif
);

   localparam int            DEPTH       = 1 << FIFO_AW;
   localparam int            EW          = 12 + L1ADDRWIDTH;
   localparam logic [7:0]    MAX_HITS_C  = 8'(MAX_HITS);
   localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_READ, S_GAP, S_TRAILER
   } state_t;

   state_t                 state, next_state;
   logic [EW-1:0]          fifo_mem [DEPTH];
   logic [FIFO_AW-1:0]     wr_ptr, rd_ptr;
   logic [FIFO_AW:0]       fifo_cnt;
   logic                   fifo_empty, fifo_full, push, pop;
   logic [EW-1:0]          fifo_head;
   logic [11:0]            cur_bcid;
   logic [3:0]             settle_cnt;
   logic [7:0]             hit_cnt;
   logic                   truncated;
   logic [DATAWIDTH-1:0]   data_word;
   logic                   data_keep;

   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = fifo_cnt[FIFO_AW];
   assign push       = inL1A && !fifo_full;
   assign fifo_head  = fifo_mem[rd_ptr];
   assign busy       = (state != S_IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {inBCID, inL1Addr};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_cnt    <= '0;
         l1aOverflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
         if (inL1A && fifo_full) l1aOverflow <= 1'b1;
      end
   end

   // Event context: dnL1Addr doubles as the current event's address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         dnL1Addr   <= '0;
         cur_bcid   <= '0;
         settle_cnt <= '0;
         hit_cnt    <= '0;
         truncated  <= 1'b0;
         data_word  <= '0;
         data_keep  <= 1'b0;
      end else begin
         state <= next_state;
         if (pop) begin
            dnL1Addr <= fifo_head[L1ADDRWIDTH-1:0];
            cur_bcid <= fifo_head[EW-1:L1ADDRWIDTH];
         end
         if (state == S_LOAD)   settle_cnt <= '0;
         if (state == S_SETTLE) settle_cnt <= settle_cnt + 1'b1;
         if (dnRead) begin
            if (hit_cnt < MAX_HITS_C) begin
               data_word <= dnData;
               data_keep <= 1'b1;
               hit_cnt   <= hit_cnt + 8'd1;
            end else begin
               data_keep <= 1'b0;
               truncated <= 1'b1;
            end
         end
         if (state == S_TRAILER) begin
            hit_cnt   <= '0;
            truncated <= 1'b0;
         end
      end
   end

   always_comb begin
      next_state = state;
      pop        = 1'b0;
      dnLoad     = 1'b0;
      dnRead     = 1'b0;
      dout       = '0;
      doutType   = 2'b00;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               next_state = S_LOAD;
            end
         end
         S_LOAD: begin
            dnLoad     = 1'b1;
            doutType   = 2'b01;
            dout       = DATAWIDTH'({cur_bcid, dnL1Addr});
            next_state = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) next_state = S_READ;
         end
         S_READ: begin
            if (!dnUnreadHit) begin
               next_state = S_TRAILER;
            end else if (!streamBufAlmostFull) begin
               dnRead     = 1'b1;
               next_state = S_GAP;
            end
         end
         S_GAP: begin
            // Discarded (over-limit) reads still pass through here silently.
            if (data_keep) begin
               doutType = 2'b10;
               dout     = data_word;
            end
            next_state = S_READ;
         end
         S_TRAILER: begin
            doutType   = 2'b11;
            dout       = DATAWIDTH'({truncated, hit_cnt, dnL1Addr});
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

`ifdef STATUS_COUNTERS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         l1aCount   <= '0;
         hitCount   <= '0;
         readCount  <= '0;
         eventCount <= '0;
      end else begin
         if (inL1A)               l1aCount   <= l1aCount + 32'd1;
         if (dnUnreadHit)         hitCount   <= hitCount + 32'd1;
         if (dnRead)              readCount  <= readCount + 32'd1;
         if (state == S_TRAILER)  eventCount <= eventCount + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_readout_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_readout_scheduler
//  Purpose  : Directed self-checking bench with a behavioural hit-chain model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pixel_readout_scheduler;

   localparam int AW = 7;
   localparam int DW = 46;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          inL1A = 1'b0;
   logic [AW-1:0] inL1Addr = '0;
   logic [11:0]   inBCID = '0;
   logic          dnUnreadHit;
   logic [DW-1:0] dnData;
   logic          streamBufAlmostFull = 1'b0;
   logic          dnLoad, dnRead, busy, l1aOverflow;
   logic [AW-1:0] dnL1Addr;
   logic [DW-1:0] dout;
   logic [1:0]    doutType;
`ifdef STATUS_COUNTERS_EN
   logic [31:0]   l1aCount, hitCount, readCount, eventCount;
`endif

   pixel_readout_scheduler dut (
      .clk(clk), .reset(reset), .inL1A(inL1A), .inL1Addr(inL1Addr), .inBCID(inBCID),
      .dnUnreadHit(dnUnreadHit), .dnData(dnData), .streamBufAlmostFull(streamBufAlmostFull),
      .dnLoad(dnLoad), .dnL1Addr(dnL1Addr), .dnRead(dnRead), .dout(dout),
      .doutType(doutType), .busy(busy), .l1aOverflow(l1aOverflow)
`ifdef STATUS_COUNTERS_EN
      , .l1aCount(l1aCount), .hitCount(hitCount), .readCount(readCount), .eventCount(eventCount)
`endif
   );

   always #5 clk = ~clk;

   // Hit chain: words [rd_cnt, chain_hi) are unread; each dnRead pops one.
   logic [DW-1:0] chain_mem [0:1023];
   int rd_cnt = 0;
   int chain_hi = 0;
   always @(posedge clk) if (dnRead && rd_cnt < chain_hi) rd_cnt <= rd_cnt + 1;
   assign dnUnreadHit = (rd_cnt < chain_hi);
   assign dnData      = chain_mem[rd_cnt];

   typedef struct { logic [1:0] t; logic [DW-1:0] d; int c; } fw_t;
   fw_t fq[$];
   int  rdq[$];
   int  ldq[$];
   int  cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (doutType != 2'b00) fq.push_back('{doutType, dout, cyc});
      if (dnRead) rdq.push_back(cyc);
      if (dnLoad) ldq.push_back(cyc);
   end

   typedef struct {
      logic [AW-1:0] addr;
      logic [11:0]   bcid;
      int            nhits;
      int            exp_words;
      int            exp_reads;
      logic [7:0]    exp_hitcnt;
      logic          exp_trunc;
   } vec_t;
   vec_t vecs[5];

   int pass_cnt = 0;
   int total_cnt = 0;
   int l1a_sent = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic fw_t get_fw(input int idx);
      fw_t r;
      r = '{2'b00, '0, -1};
      if (idx >= 0 && idx < fq.size()) r = fq[idx];
      return r;
   endfunction

   task automatic preload(input int n, output int base);
      base = chain_hi;
      for (int i = 0; i < n; i++)
         chain_mem[chain_hi + i] = DW'(46'h15_5500_0000) ^ DW'((chain_hi + i) * 32'h0103_0507);
      chain_hi = chain_hi + n;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check({name, "_timeout"}, 64'(k >= 2000), 64'd0);
   endtask

   task automatic check_frame(input string tag, input int fb, input int base, input vec_t v);
      fw_t w;
      check({tag, "_nwords"}, 64'(fq.size() - fb), 64'(v.exp_words + 2));
      w = get_fw(fb);
      check({tag, "_hdr_type"}, 64'(w.t), 64'd1);
      check({tag, "_hdr"}, 64'(w.d), 64'({v.bcid, v.addr}));
      for (int i = 0; i < v.exp_words; i++) begin
         w = get_fw(fb + 1 + i);
         check($sformatf("%s_data%0d", tag, i), {w.t, 16'h0, w.d}, {2'b10, 16'h0, chain_mem[base + i]});
      end
      w = get_fw(fb + 1 + v.exp_words);
      check({tag, "_trl_type"}, 64'(w.t), 64'd3);
      check({tag, "_trl"}, 64'(w.d), 64'({v.exp_trunc, v.exp_hitcnt, v.addr}));
   endtask

   task automatic send_l1a(input logic [AW-1:0] a, input logic [11:0] b);
      inL1A = 1'b1; inL1Addr = a; inBCID = b; l1a_sent++;
      @(negedge clk);
      inL1A = 1'b0;
   endtask

   task automatic run_event(input string tag, input vec_t v);
      int fb, rb, lb, base;
      @(negedge clk);
      preload(v.nhits, base);
      fb = fq.size(); rb = rdq.size(); lb = ldq.size();
      send_l1a(v.addr, v.bcid);
      wait_idle(tag);
      check_frame(tag, fb, base, v);
      check({tag, "_reads"}, 64'(rdq.size() - rb), 64'(v.exp_reads));
      check({tag, "_chain_empty"}, 64'(dnUnreadHit), 64'd0);
      check({tag, "_l1addr_held"}, 64'(dnL1Addr), 64'(v.addr));
      if (v.nhits >= 2 && rdq.size() - rb >= 2 && ldq.size() > lb) begin
         check({tag, "_hdr_with_load"}, 64'(get_fw(fb).c), 64'(ldq[lb]));
         check({tag, "_first_read_lat"}, 64'(rdq[rb] - ldq[lb]), 64'd3);
         for (int i = rb + 1; i < rdq.size(); i++)
            check($sformatf("%s_read_gap%0d", tag, i - rb), 64'(rdq[i] - rdq[i-1]), 64'd2);
      end
   endtask

   initial begin
      int fb, rb, base, k, rd0, fq0, trl;
      vec_t v;
      vecs[0] = '{7'h15, 12'h123, 3,  3,  3,  8'd3,  1'b0};
      vecs[1] = '{7'h2A, 12'hABC, 0,  0,  0,  8'd0,  1'b0};
      vecs[2] = '{7'h7F, 12'hFFF, 20, 16, 20, 8'd16, 1'b1};
      vecs[3] = '{7'h01, 12'h001, 16, 16, 16, 8'd16, 1'b0};
      vecs[4] = '{7'h40, 12'h800, 1,  1,  1,  8'd1,  1'b0};

      repeat (3) @(negedge clk);
      check("rst_outputs", {dnLoad, dnRead, busy, l1aOverflow, doutType, dnL1Addr, dout}, 64'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) run_event($sformatf("vec%0d", i), vecs[i]);
      check("no_overflow_yet", 64'(l1aOverflow), 64'd0);

      // Back-pressure for 10 cycles in the middle of a drain.
      v = '{7'h33, 12'h5A5, 4, 4, 4, 8'd4, 1'b0};
      @(negedge clk);
      preload(4, base);
      fb = fq.size();
      send_l1a(v.addr, v.bcid);
      k = 0;
      while (!dnRead && k < 100) begin @(negedge clk); k++; end
      check("bp_first_read", 64'(k < 100), 64'd1);
      @(negedge clk);
      streamBufAlmostFull = 1'b1;
      rb = rdq.size();
      repeat (10) @(negedge clk);
      check("bp_no_reads", 64'(rdq.size() - rb), 64'd0);
      check("bp_still_busy", 64'(busy), 64'd1);
      streamBufAlmostFull = 1'b0;
      wait_idle("bp");
      check_frame("bp", fb, base, v);
      check("bp_reads_after", 64'(rdq.size() - rb), 64'd3);

      // Six back-to-back L1As into a depth-4 queue: one is dropped.
      @(negedge clk);
      fb = fq.size();
      for (int i = 0; i < 6; i++) begin
         inL1A = 1'b1; inL1Addr = AW'(7'h10 + i); inBCID = 12'(12'h100 + i); l1a_sent++;
         @(negedge clk);
      end
      inL1A = 1'b0;
      check("ovf_sticky", 64'(l1aOverflow), 64'd1);
      wait_idle("ovf");
      check("ovf_nwords", 64'(fq.size() - fb), 64'd10);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("ovf_hdr%0d", i), {get_fw(fb + 2*i).t, 62'(get_fw(fb + 2*i).d)},
               {2'b01, 62'({12'(12'h100 + i), AW'(7'h10 + i)})});
         check($sformatf("ovf_trl%0d", i), {get_fw(fb + 2*i + 1).t, 62'(get_fw(fb + 2*i + 1).d)},
               {2'b11, 62'({1'b0, 8'd0, AW'(7'h10 + i)})});
      end

      // Reset asserted while reading.
      @(negedge clk);
      preload(5, base);
      send_l1a(7'h22, 12'h321);
      k = 0;
      while (!dnRead && k < 100) begin @(negedge clk); k++; end
      check("rst_reach_read", 64'(k < 100), 64'd1);
      reset = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_outputs", {dnLoad, dnRead, busy, l1aOverflow, doutType, dnL1Addr, dout}, 64'd0);
      @(negedge clk);
      chain_hi = rd_cnt;
      reset = 1'b1;
      l1a_sent = 0;
      rd0 = rdq.size();
      fq0 = fq.size();
      run_event("post_rst", '{7'h0B, 12'h456, 2, 2, 2, 8'd2, 1'b0});
      check("post_rst_ovf_clear", 64'(l1aOverflow), 64'd0);
`ifdef STATUS_COUNTERS_EN
      trl = 0;
      for (int i = fq0; i < fq.size(); i++) if (fq[i].t == 2'b11) trl++;
      check("cnt_l1a", 64'(l1aCount), 64'(l1a_sent));
      check("cnt_read", 64'(readCount), 64'(rdq.size() - rd0));
      check("cnt_event", 64'(eventCount), 64'(trl));
`else
      trl = 0;
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
